uart_frame_loader: RTL and testbench
====================================

Name: uart_frame_loader

Overview:
- Downstream stage of the UART byte receiver.
- Turns the received byte stream into a framed image load: sync byte, 16-bit width, 16-bit height, then width*height 8-bit pixels.
- Each pixel is written into the frame buffer through a simple synchronous write port.
- Signals frame completion or error to the image-processing control logic.

Parameters:
- ADDR_W, 16, frame-buffer address width; max pixel count is 2**ADDR_W.
- SYNC_BYTE, 8'hA5, header sync value.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- rx_done  in  1  receiver byte-done level; rises after the stop bit, stays high until the next start bit
- rx_data  in  8  received byte; valid while rx_done is high
- mem_we  out  1  frame-buffer write strobe, one cycle per pixel
- mem_addr  out  ADDR_W  pixel address, 0-based, raster order
- mem_wdata  out  8  pixel value
- img_width  out  16  latched frame width
- img_height  out  16  latched frame height
- busy  out  1  high from accepted sync byte until DONE/ERR
- frame_done  out  1  one-cycle pulse, frame fully written
- frame_err  out  1  one-cycle pulse, header rejected or checksum mismatch

Behaviour:
- Reset is asynchronous, active-high. All outputs reset to 0, state resets to IDLE, counters reset to 0.
- Byte strobe: byte_stb = rx_done & ~rx_done_q.
  - rx_done_q resets to 1, so a level already high at reset release is not counted.
  - rx_data is captured in the byte_stb cycle.
- States: IDLE, W_HI, W_LO, H_HI, H_LO, CHECK, PIXELS, CSUM (only with the option), DONE, ERR.
- IDLE: on byte_stb, if the byte equals SYNC_BYTE go to W_HI and set busy; any other byte is discarded.
- W_HI/W_LO/H_HI/H_LO: each byte_stb loads the big-endian halves of img_width and img_height.
  - img_width/img_height update at the end of H_LO and hold until the next accepted header.
- CHECK: one cycle. Computes total = img_width*img_height (32-bit unsigned).
  - If total == 0 or total > 2**ADDR_W, go to ERR.
  - Otherwise load pix_cnt = 0 and go to PIXELS.
- PIXELS: on each byte_stb in cycle N:
  - cycle N+1 drives mem_we=1, mem_addr=pix_cnt, mem_wdata=byte; pix_cnt then increments.
  - After the write with pix_cnt == total-1, go to DONE (or CSUM when the option is compiled in).
  - Latency from byte_stb to mem_we is 1 cycle. mem_we is never high in two consecutive cycles.
- DONE: frame_done=1 for one cycle, busy=0, return to IDLE.
- ERR: frame_err=1 for one cycle, busy=0, return to IDLE. No memory writes occur from ERR.
- Bytes equal to SYNC_BYTE inside the header or payload are data, not resync.
- A byte_stb arriving during CHECK/DONE/ERR is dropped. The receiver's minimum byte period makes this impossible at spec baud rates.
- mem_addr arithmetic is ADDR_W bits. total == 2**ADDR_W is legal; the last address is all-ones, and no wrap write occurs.
- Asserting rst mid-frame aborts immediately. Bytes already written stay in the frame buffer, but no frame_done is issued.

Optional Feature:
- Macro: UART_FRAME_CHECKSUM_EN.
- Defined:
  - A running 8-bit XOR of all width, height and pixel bytes (sync excluded) is kept.
  - After the last pixel, state CSUM waits for one more byte.
  - If that byte equals the running XOR go to DONE, else go to ERR.
  - Pixels are written regardless of the checksum result.
- Not defined: the CSUM state and the XOR register do not exist; the last pixel goes straight to DONE.

Decomposition:
- Package uart_frame_pkg holds:
  - the state enum encoding,
  - SYNC_BYTE default,
  - header length constant (4),
  - the CHECK error rule constants.
- One natural sub-module: uart_byte_strobe, holding the rx_done edge detector and rx_data capture register. It outputs byte_stb and byte_q.

Test Plan:
- Frame A5 00 02 00 02 11 22 33 44 -> mem writes (0,11),(1,22),(2,33),(3,44); img_width=2, img_height=2; one frame_done pulse; busy low afterwards.
- Garbage 00 FF 5A, then a valid 1x1 frame A5 00 01 00 01 7E -> garbage ignored; single write (0,7E); frame_done.
- Header A5 00 00 00 05 -> frame_err pulse, no mem_we; then a valid 1x1 frame completes normally.
- ADDR_W=4, header A5 00 04 00 04 (16 pixels) -> succeeds with last addr 0xF; header A5 00 05 00 04 -> frame_err.
- rx_done held high through reset release -> no byte accepted; rst asserted after 2 of 4 pixels -> busy=0 immediately, no frame_done, next frame starts at addr 0.
- With UART_FRAME_CHECKSUM_EN: A5 00 01 00 02 10 20 plus checksum 0x33 -> frame_done; same frame with checksum 0x00 -> frame_err, both pixels still written.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared state encoding, header constants and header validity rule for the UART frame loader.
// Defining UART_FRAME_CHECKSUM_EN adds the CSUM state used by the trailing XOR checksum byte.
package uart_frame_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        W_HI   = 4'd1,
        W_LO   = 4'd2,
        H_HI   = 4'd3,
        H_LO   = 4'd4,
        CHECK  = 4'd5,
        PIXELS = 4'd6,
`ifdef UART_FRAME_CHECKSUM_EN
        CSUM   = 4'd7,
`endif
        DONE   = 4'd8,
        ERR    = 4'd9
    } frameState_t;

    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int          HDR_LEN           = 4;
    localparam logic [31:0] TOTAL_MIN         = 32'd1;

    // A frame is rejected when it carries no pixels or more pixels than the buffer holds.
    function automatic logic headerInvalid(input logic [31:0] total, input int unsigned addrW);
        logic [63:0] limit;
        limit = 64'd1 << addrW;
        return (total < TOTAL_MIN) || ({32'd0, total} > limit);
    endfunction

endpackage

// File: rtl/uart_byte_strobe.sv
// Turns the receiver's byte-done level into a single-cycle strobe and captures the byte.
// The edge register resets high so a level already present at reset release is ignored.
module uart_byte_strobe (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    output logic       byte_stb,
    output logic [7:0] byte_q
);

    logic rxDoneQ;

    assign byte_stb = rx_done & ~rxDoneQ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxDoneQ <= 1'b1;
            byte_q  <= '0;
        end else begin
            rxDoneQ <= rx_done;
            if (byte_stb) begin
                byte_q <= rx_data;
            end
        end
    end

endmodule

// File: rtl/uart_frame_loader.sv
// Parses sync/width/height/pixels from the UART byte stream and writes pixels to the frame buffer.
// Optional UART_FRAME_CHECKSUM_EN: a trailing XOR checksum byte decides between DONE and ERR.
module uart_frame_loader
    import uart_frame_pkg::*;
#(
    parameter int         ADDR_W    = 16,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_done,
    input  logic [7:0]        rx_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic [15:0]       img_width,
    output logic [15:0]       img_height,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err
);

    frameState_t stateReg, stateNext;

    logic                     byteStb;
    logic [7:0]               byteQ;
    logic [HDR_LEN-2:0][7:0]  hdrReg;
    logic [15:0]              imgWidthReg, imgHeightReg;
    logic [31:0]              total;
    logic [ADDR_W-1:0]        pixCntReg, lastAddrReg, memAddrReg;
    logic                     memWeReg, lastWrReg;
    logic                     hdrShift, pixAccept;

    uart_byte_strobe uStrobe (
        .clk      (clk),
        .rst      (rst),
        .rx_done  (rx_done),
        .rx_data  (rx_data),
        .byte_stb (byteStb),
        .byte_q   (byteQ)
    );

    assign total     = 32'(imgWidthReg) * 32'(imgHeightReg);
    assign hdrShift  = byteStb && (stateReg inside {W_HI, W_LO, H_HI});
    // A strobe landing on a write cycle is dropped so writes never run back to back.
    assign pixAccept = byteStb && (stateReg == PIXELS) && !memWeReg;

`ifdef UART_FRAME_CHECKSUM_EN
    logic [7:0] csumReg;
    logic       csumTake;

    assign csumTake = pixAccept || (byteStb && (stateReg inside {W_HI, W_LO, H_HI, H_LO}));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csumReg <= '0;
        end else if (stateReg == IDLE) begin
            csumReg <= '0;
        end else if (csumTake) begin
            csumReg <= csumReg ^ rx_data;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext  = stateReg;
        busy       = 1'b0;
        frame_done = 1'b0;
        frame_err  = 1'b0;
        unique case (stateReg)
            IDLE: begin
                if (byteStb && (rx_data == SYNC_BYTE)) begin
                    stateNext = W_HI;
                end
            end
            W_HI: begin
                busy = 1'b1;
                if (byteStb) stateNext = W_LO;
            end
            W_LO: begin
                busy = 1'b1;
                if (byteStb) stateNext = H_HI;
            end
            H_HI: begin
                busy = 1'b1;
                if (byteStb) stateNext = H_LO;
            end
            H_LO: begin
                busy = 1'b1;
                if (byteStb) stateNext = CHECK;
            end
            CHECK: begin
                busy      = 1'b1;
                stateNext = headerInvalid(total, ADDR_W) ? ERR : PIXELS;
            end
            PIXELS: begin
                busy = 1'b1;
                if (memWeReg && lastWrReg) begin
`ifdef UART_FRAME_CHECKSUM_EN
                    stateNext = CSUM;
`else
                    stateNext = DONE;
`endif
                end
            end
`ifdef UART_FRAME_CHECKSUM_EN
            CSUM: begin
                busy = 1'b1;
                if (byteStb) stateNext = (rx_data == csumReg) ? DONE : ERR;
            end
`endif
            DONE: begin
                frame_done = 1'b1;
                stateNext  = IDLE;
            end
            ERR: begin
                frame_err = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdrReg       <= '0;
            imgWidthReg  <= '0;
            imgHeightReg <= '0;
            pixCntReg    <= '0;
            lastAddrReg  <= '0;
            memAddrReg   <= '0;
            memWeReg     <= 1'b0;
            lastWrReg    <= 1'b0;
        end else begin
            memWeReg <= 1'b0;
            if (hdrShift) begin
                hdrReg <= {hdrReg[HDR_LEN-3:0], rx_data};
            end
            // Width/height become visible only once the whole header has arrived.
            if (byteStb && (stateReg == H_LO)) begin
                imgWidthReg  <= {hdrReg[2], hdrReg[1]};
                imgHeightReg <= {hdrReg[0], rx_data};
            end
            if (stateReg == CHECK) begin
                pixCntReg   <= '0;
                lastAddrReg <= ADDR_W'(total - 32'd1);
            end
            if (pixAccept) begin
                memWeReg   <= 1'b1;
                memAddrReg <= pixCntReg;
                lastWrReg  <= (pixCntReg == lastAddrReg);
                pixCntReg  <= pixCntReg + 1'b1;
            end
        end
    end

    assign mem_we     = memWeReg;
    assign mem_addr   = memAddrReg;
    assign mem_wdata  = byteQ;
    assign img_width  = imgWidthReg;
    assign img_height = imgHeightReg;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Randomized self-checking bench for uart_frame_loader against a byte-stream frame model.
// Built with UART_FRAME_CHECKSUM_EN, frames carry a trailing XOR checksum byte.
module tb_uart_frame_loader;

    localparam int         ADDR_W = 4;
    localparam logic [7:0] SYNC   = 8'hA5;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              rx_done;
    logic [7:0]        rx_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [15:0]       img_width;
    logic [15:0]       img_height;
    logic              busy;
    logic              frame_done;
    logic              frame_err;

    always #5 clk = ~clk;

    uart_frame_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(SYNC)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_done    (rx_done),
        .rx_data    (rx_data),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .img_width  (img_width),
        .img_height (img_height),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    int errors = 0;
    int checks = 0;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: collects every write and counts pulses; tests compare deltas.
    wr_t  seenQ[$];
    int   doneCnt = 0;
    int   errCnt  = 0;
    int   dblWe   = 0;
    logic weQ     = 1'b0;

    always @(negedge clk) begin
        if (mem_we === 1'b1) seenQ.push_back('{addr: mem_addr, data: mem_wdata});
        if (mem_we === 1'b1 && weQ) dblWe <= dblWe + 1;
        if (frame_done === 1'b1) doneCnt <= doneCnt + 1;
        if (frame_err === 1'b1) errCnt <= errCnt + 1;
        weQ <= (mem_we === 1'b1);
    end

    // Reference model state, derived from the byte list of one transaction.
    wr_t         expQ[$];
    logic        pixFlag[$];
    logic        expDone, expErr, expHdr;
    logic [15:0] expW, expH;

    task automatic model(input bq_t b);
        int     s;
        longint tot;
        logic [7:0] x;
        expQ.delete();
        pixFlag.delete();
        expDone = 0; expErr = 0; expHdr = 0; expW = 0; expH = 0;
        foreach (b[i]) pixFlag.push_back(1'b0);
        s = -1;
        for (int i = 0; i < b.size(); i++) if (s < 0 && b[i] == SYNC) s = i;
        if (s < 0 || b.size() < s + 5) return;
        expHdr = 1;
        expW   = {b[s+1], b[s+2]};
        expH   = {b[s+3], b[s+4]};
        tot    = longint'(expW) * longint'(expH);
        if (tot == 0 || tot > (longint'(1) << ADDR_W)) begin
            expErr = 1;
            return;
        end
        for (int k = 0; k < tot; k++) begin
            expQ.push_back('{addr: ADDR_W'(k), data: b[s+5+k]});
            pixFlag[s+5+k] = 1'b1;
        end
`ifdef UART_FRAME_CHECKSUM_EN
        x = 8'h00;
        for (int j = s + 1; j <= s + 4 + int'(tot); j++) x ^= b[j];
        if (b[s+5+int'(tot)] == x) expDone = 1; else expErr = 1;
`else
        expDone = 1;
`endif
    endtask

    task automatic sendByte(input logic [7:0] b, input logic isPix);
        @(posedge clk); #1;
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkVal("we_latency", mem_we, isPix);
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        rx_done = 1'b0;
        rx_data = 8'($urandom);
        repeat ($urandom_range(2, 4)) @(posedge clk);
    endtask

    function automatic bq_t addCsum(input bq_t b, input logic good);
        bq_t r = b;
`ifdef UART_FRAME_CHECKSUM_EN
        logic [7:0] x = 8'h00;
        for (int i = 1; i < b.size(); i++) x ^= b[i];
        r.push_back(good ? x : ~x);
`else
        if (good) r = b;
`endif
        return r;
    endfunction

    task automatic runFrame(input string name, input bq_t b);
        int baseW, baseD, baseE, baseDbl, nw, n;
        model(b);
        baseW = seenQ.size(); baseD = doneCnt; baseE = errCnt; baseDbl = dblWe;
        foreach (b[i]) sendByte(b[i], pixFlag[i]);
        repeat (8) @(posedge clk);
        @(negedge clk);
        nw = seenQ.size() - baseW;
        checkVal({name, "_nwrites"}, nw, expQ.size());
        n = (nw < expQ.size()) ? nw : expQ.size();
        for (int k = 0; k < n; k++) begin
            checkVal({name, "_addr"}, seenQ[baseW+k].addr, expQ[k].addr);
            checkVal({name, "_data"}, seenQ[baseW+k].data, expQ[k].data);
        end
        checkVal({name, "_done"}, doneCnt - baseD, expDone);
        checkVal({name, "_err"}, errCnt - baseE, expErr);
        checkVal({name, "_busy"}, busy, 1'b0);
        checkVal({name, "_dblwe"}, dblWe - baseDbl, 0);
        if (expHdr) begin
            checkVal({name, "_width"}, img_width, expW);
            checkVal({name, "_height"}, img_height, expH);
        end
        $display("frame %s: bytes=%0d w=%0d h=%0d writes=%0d exp_done=%0d exp_err=%0d",
                 name, b.size(), expW, expH, nw, expDone, expErr);
    endtask

    initial begin
        bq_t b;
        int  baseW, baseD;
        logic [7:0] g;
        logic [15:0] w, h;

        // rx_done already high across reset release must not count as a byte.
        rst = 1'b1; rx_done = 1'b1; rx_data = SYNC;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkVal("rst_we", mem_we, 1'b0);
        checkVal("rst_addr", mem_addr, '0);
        checkVal("rst_wdata", mem_wdata, 8'h00);
        checkVal("rst_width", img_width, 16'h0);
        checkVal("rst_height", img_height, 16'h0);
        checkVal("rst_busy", busy, 1'b0);
        checkVal("rst_done", frame_done, 1'b0);
        checkVal("rst_err", frame_err, 1'b0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checkVal("held_rx_done_busy", busy, 1'b0);
        $display("reset: rx_done held high through release, busy=%0b", busy);
        @(posedge clk); #1 rx_done = 1'b0;
        repeat (3) @(posedge clk);

        b = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
        runFrame("dir_2x2", addCsum(b, 1'b1));
        b = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h01, 8'h00, 8'h01, 8'h7E};
        runFrame("dir_garbage_1x1", addCsum(b, 1'b1));
        b = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h05};
        runFrame("dir_zero_width", b);
        b = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h01, 8'hA5};
        runFrame("dir_1x1_sync_data", addCsum(b, 1'b1));
        b = '{8'hA5, 8'h00, 8'h04, 8'h00, 8'h04};
        for (int i = 0; i < 16; i++) b.push_back(8'(8'hF0 + i));
        runFrame("dir_4x4_full", addCsum(b, 1'b1));
        b = '{8'hA5, 8'h00, 8'h05, 8'h00, 8'h04};
        runFrame("dir_5x4_too_big", b);
`ifdef UART_FRAME_CHECKSUM_EN
        b = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h02, 8'h10, 8'h20, 8'h33};
        runFrame("dir_csum_good", b);
        b = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h02, 8'h10, 8'h20, 8'h00};
        runFrame("dir_csum_bad", b);
`endif

        // Reset in the middle of the payload: abort at once, no completion pulse.
        baseW = seenQ.size(); baseD = doneCnt;
        b = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h02, 8'h11, 8'h22};
        foreach (b[i]) sendByte(b[i], i >= 5);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkVal("midrst_busy", busy, 1'b0);
        checkVal("midrst_we", mem_we, 1'b0);
        repeat (3) @(negedge clk);
        checkVal("midrst_writes", seenQ.size() - baseW, 2);
        checkVal("midrst_done", doneCnt - baseD, 0);
        rst = 1'b0;
        $display("reset: mid-frame abort after 2 pixels, writes=%0d", seenQ.size() - baseW);
        repeat (3) @(posedge clk);
        b = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h02, 8'h55, 8'h66, 8'h77, 8'h88};
        runFrame("after_rst", addCsum(b, 1'b1));

        for (int t = 0; t < 30; t++) begin
            b.delete();
            repeat ($urandom_range(0, 3)) begin
                do g = 8'($urandom); while (g == SYNC);
                b.push_back(g);
            end
            w = ($urandom_range(0, 9) == 0) ? 16'h0100 : 16'($urandom_range(0, 5));
            h = 16'($urandom_range(0, 5));
            b.push_back(SYNC);
            b.push_back(w[15:8]); b.push_back(w[7:0]);
            b.push_back(h[15:8]); b.push_back(h[7:0]);
            if (w * h != 0 && 32'(w) * 32'(h) <= (32'd1 << ADDR_W)) begin
                for (int k = 0; k < int'(w * h); k++)
                    b.push_back(($urandom_range(0, 7) == 0) ? SYNC : 8'($urandom));
                b = addCsum(b, $urandom_range(0, 2) != 0);
            end
            runFrame($sformatf("rand%0d", t), b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
